updown_counter: RTL

Parametrised, fully synchronous up/down counter with programmable modulus, parallel load and terminal-count/wrap flags. It succeeds the fixed 4-bit ripple up-counter: every bit is clocked from the single system clock, so there is no ripple skew or glitching between bits. It is the general-purpose counting primitive for timers, dividers and address sequencers in the design.

---
 rtl/updown_counter.sv | 72 +++++++
 1 files changed

// File: rtl/updown_counter.sv
// Fully synchronous up/down counter with programmable modulus, clamped parallel load,
// combinational terminal count and registered wrap pulse. Define UPDOWN_COUNTER_SATURATE_EN to saturate instead of wrapping.
module updown_counter #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic             at_max;
  logic             at_zero;
  logic [WIDTH-1:0] load_clamped;

  assign at_max       = (q == MAX_COUNT);
  assign at_zero      = (q == ZERO);
  assign load_clamped = (load_val > MAX_COUNT) ? MAX_COUNT : load_val;

  // Zero-latency so it can enable the next stage of a cascade in the same cycle.
  assign tc = en & (up ? at_max : at_zero);

  always_ff @(posedge clk) begin
    if (reset) begin
      q    <= ZERO;
      wrap <= 1'b0;
    end else if (load) begin
      q    <= load_clamped;
      wrap <= 1'b0;
    end else if (en) begin
      if (up) begin
        if (at_max) begin
`ifdef UPDOWN_COUNTER_SATURATE_EN
          q    <= MAX_COUNT;
          wrap <= 1'b0;
`else
          q    <= ZERO;
          wrap <= 1'b1;
`endif
        end else begin
          q    <= q + ONE;
          wrap <= 1'b0;
        end
      end else begin
        if (at_zero) begin
`ifdef UPDOWN_COUNTER_SATURATE_EN
          q    <= ZERO;
          wrap <= 1'b0;
`else
          q    <= MAX_COUNT;
          wrap <= 1'b1;
`endif
        end else begin
          q    <= q - ONE;
          wrap <= 1'b0;
        end
      end
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule
